// File: rtl/cpu_garage_pkg.sv
// Shared widths, Hack instruction field positions and the C-instruction layout.
package cpu_garage_pkg;

  localparam int unsigned WordW = 16;
  localparam int unsigned AddrW = 15;

  // Instruction bit positions
  localparam int unsigned InstTypeBit = 15;
  localparam int unsigned ASelBit     = 12;
  localparam int unsigned CompMsb     = 11;
  localparam int unsigned CompLsb     = 6;
  localparam int unsigned DestMsb     = 5;
  localparam int unsigned DestLsb     = 3;
  localparam int unsigned JumpMsb     = 2;
  localparam int unsigned JumpLsb     = 0;

  // C-instruction, msb first; ign covers bits [14:13], which carry no meaning
  typedef struct packed {
    logic       is_c;
    logic [1:0] ign;
    logic       a;
    logic       zx;
    logic       nx;
    logic       zy;
    logic       ny;
    logic       f;
    logic       no;
    logic       dst_a;
    logic       dst_d;
    logic       dst_m;
    logic       jlt;
    logic       jeq;
    logic       jgt;
  } c_inst_t;

endpackage

// File: rtl/cpu_garage_core.sv
// Hack core: PC, A and D registers, instruction decode and ALU, single cycle.
module cpu_garage_core
  import cpu_garage_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WordW-1:0] instr_i,
  input  logic [WordW-1:0] in_m_i,
  output logic [AddrW-1:0] pc_o,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [WordW-1:0] out_m_o
);

  logic [AddrW-1:0] pc_q, pc_d;
  logic [WordW-1:0] a_q, a_d;
  logic [WordW-1:0] d_q, d_d;

  c_inst_t          inst;
  logic [WordW-1:0] alu_x, alu_y, alu_out;
  logic             zr, ng, jump;
  logic             unused_ign;

  assign inst       = c_inst_t'(instr_i);
  assign unused_ign = ^inst.ign;

  // ALU: x is D, y is A or M; zero/invert each operand, add or and, invert result
  always_comb begin
    alu_x = d_q;
    alu_y = inst.a ? in_m_i : a_q;
    if (inst.zx) alu_x = '0;
    if (inst.nx) alu_x = ~alu_x;
    if (inst.zy) alu_y = '0;
    if (inst.ny) alu_y = ~alu_y;
    alu_out = inst.f ? (alu_x + alu_y) : (alu_x & alu_y);
    if (inst.no) alu_out = ~alu_out;
  end

  assign zr   = (alu_out == '0);
  assign ng   = alu_out[WordW-1];
  assign jump = inst.is_c & ((inst.jlt & ng) | (inst.jeq & zr) | (inst.jgt & ~ng & ~zr));

  // Next state: everything keys off the pre-edge A, so AM=... writes the old address
  always_comb begin
    pc_d = pc_q + 1'b1;
    a_d  = a_q;
    d_d  = d_q;
    if (!inst.is_c) begin
      a_d = {1'b0, instr_i[AddrW-1:0]};
    end else begin
      if (inst.dst_a) a_d = alu_out;
      if (inst.dst_d) d_d = alu_out;
      if (jump)       pc_d = a_q[AddrW-1:0];
    end
  end

  // Architectural state, cleared asynchronously and held while reset is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
      a_q  <= '0;
      d_q  <= '0;
    end else begin
      pc_q <= pc_d;
      a_q  <= a_d;
      d_q  <= d_d;
    end
  end

  assign pc_o    = pc_q;
  assign we_o    = inst.is_c & inst.dst_m;
  assign addr_o  = a_q[AddrW-1:0];
  assign out_m_o = alu_out;

endmodule

// File: rtl/cpu_garage_rom.sv
// Instruction ROM: combinational read, contents supplied from outside (never reset).
module cpu_garage_rom
  import cpu_garage_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 1024
) (
  input  logic [AddrW-1:0] addr_i,
  output logic [WordW-1:0] data_o
);

  localparam int unsigned RomAw = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  logic [WordW-1:0] mem [ROM_DEPTH-1:0];

  // Fetch at PC reduced modulo the ROM depth
  always_comb begin
    data_o = mem[RomAw'(32'(addr_i) % ROM_DEPTH)];
  end

endmodule

// File: rtl/cpu_garage.sv
// Hack computer top: core, instruction ROM and data RAM.
// Optional checks compiled in with CPU_GARAGE_ASSERT_EN.
module cpu_garage
  import cpu_garage_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 1024,
  parameter int unsigned RAM_DEPTH = 1024
) (
  input logic Clk,
  input logic Reset
);

  localparam int unsigned RamAw = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic             we;
  logic [AddrW-1:0] ram_address;
  logic [WordW-1:0] cpu_out_m;
  logic [AddrW-1:0] pc;
  logic [WordW-1:0] instr;
  logic [WordW-1:0] in_m;

  logic [WordW-1:0] ram [RAM_DEPTH-1:0];

  cpu_garage_core cpu_inst (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .instr_i (instr),
    .in_m_i  (in_m),
    .pc_o    (pc),
    .we_o    (we),
    .addr_o  (ram_address),
    .out_m_o (cpu_out_m)
  );

  cpu_garage_rom #(
    .ROM_DEPTH (ROM_DEPTH)
  ) rom_inst (
    .addr_i (pc),
    .data_o (instr)
  );

  // Asynchronous RAM read at A reduced modulo the RAM depth
  always_comb begin
    in_m = ram[RamAw'(32'(ram_address) % RAM_DEPTH)];
  end

  // RAM write; contents are never reset, and writes are blocked while in reset
  always_ff @(posedge Clk) begin
    if (we && Reset) begin
      ram[RamAw'(32'(ram_address) % RAM_DEPTH)] <= cpu_out_m;
    end
  end

`ifdef CPU_GARAGE_ASSERT_EN
  a_outputs_known: assert property (@(posedge Clk) disable iff (!Reset)
    !$isunknown({we, ram_address, cpu_out_m}));

  a_pc_in_rom: assert property (@(posedge Clk) disable iff (!Reset)
    32'(pc) < ROM_DEPTH)
    else $warning("PC %0h beyond ROM depth %0d, fetch wraps", pc, ROM_DEPTH);
`endif

endmodule

// File: tb/tb_cpu_garage.sv
// Bench for cpu_garage: directed programs plus random programs, each cycle checked
// against an instruction-level Hack reference model.
module tb_cpu_garage;

  localparam int unsigned RomD = 1024;
  localparam int unsigned RamD = 1024;

  // Hack comp codes (zx nx zy ny f no)
  localparam logic [5:0] CZero = 6'b101010, COne = 6'b111111, CNeg1 = 6'b111010;
  localparam logic [5:0] CD = 6'b001100, CA = 6'b110000, CNotD = 6'b001101;
  localparam logic [5:0] CNotA = 6'b110001, CNegD = 6'b001111, CNegA = 6'b110011;
  localparam logic [5:0] CDp1 = 6'b011111, CAp1 = 6'b110111, CDm1 = 6'b001110;
  localparam logic [5:0] CAm1 = 6'b110010, CDpA = 6'b000010, CDmA = 6'b010011;
  localparam logic [5:0] CAmD = 6'b000111, CDandA = 6'b000000, CDorA = 6'b010101;
  localparam logic [2:0] DNone = 3'b000, DM = 3'b001, DD = 3'b010, DAM = 3'b101;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  cpu_garage #(
    .ROM_DEPTH (RomD),
    .RAM_DEPTH (RamD)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rom_img [RomD];
  logic [15:0] mdl_ram [int];
  logic [14:0] m_pc;
  logic [15:0] m_a, m_d;
  logic [15:0] prog [$];
  logic [5:0]  comp_tab [18];
  logic [15:0] sweep_exp [18];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ainst(input int unsigned v);
    logic [31:0] w;
    w = v;
    return {1'b0, w[14:0]};
  endfunction

  function automatic logic [15:0] cinst(input logic a, input logic [5:0] c,
                                        input logic [2:0] dst, input logic [2:0] j);
    return {3'b111, a, c, dst, j};
  endfunction

  // ISA-table ALU: meaning of each standard comp code
  function automatic logic [15:0] alu_ref(input logic [5:0] c, input logic [15:0] x,
                                          input logic [15:0] y);
    case (c)
      CZero:   return 16'd0;
      COne:    return 16'd1;
      CNeg1:   return 16'hFFFF;
      CD:      return x;
      CA:      return y;
      CNotD:   return ~x;
      CNotA:   return ~y;
      CNegD:   return 16'd0 - x;
      CNegA:   return 16'd0 - y;
      CDp1:    return x + 16'd1;
      CAp1:    return y + 16'd1;
      CDm1:    return x - 16'd1;
      CAm1:    return y - 16'd1;
      CDpA:    return x + y;
      CDmA:    return x - y;
      CAmD:    return y - x;
      CDandA:  return x & y;
      CDorA:   return x | y;
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic logic [15:0] ram_rd(input logic [15:0] addr);
    int k;
    k = int'(addr[14:0]) % RamD;
    if (mdl_ram.exists(k)) return mdl_ram[k];
    return 16'hxxxx;
  endfunction

  // Compare one cycle at the negedge, advance the model, move to the next negedge
  task automatic cycle(input string tag);
    logic [15:0] ins, y, res;
    logic        jt;
    ins = rom_img[int'(m_pc) % RomD];
    check({tag, ".pc"}, dut.cpu_inst.pc_q, m_pc);
    check({tag, ".a"}, dut.cpu_inst.a_q, m_a);
    check({tag, ".d"}, dut.cpu_inst.d_q, m_d);
    check({tag, ".addr"}, dut.ram_address, m_a[14:0]);
    if (!ins[15]) begin
      check({tag, ".we"}, dut.we, 1'b0);
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      y   = ins[12] ? ram_rd(m_a) : m_a;
      res = alu_ref(ins[11:6], m_d, y);
      check({tag, ".we"}, dut.we, ins[3]);
      check({tag, ".outm"}, dut.cpu_out_m, res);
      jt = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'd0) ||
           (ins[0] && $signed(res) > 0);
      if (ins[3]) mdl_ram[int'(m_a[14:0]) % RamD] = res;
      m_pc = jt ? m_a[14:0] : m_pc + 15'd1;
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
    end
    @(negedge Clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Hold reset, load the program into ROM, release so the next edge runs ROM[0]
  task automatic load_and_start();
    Reset = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < RomD; i++) begin
      rom_img[i] = (i < prog.size()) ? prog[i] : 16'h0000;
      dut.rom_inst.mem[i] = rom_img[i];
    end
    m_pc = '0;
    m_a  = '0;
    m_d  = '0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    comp_tab = '{CZero, COne, CNeg1, CD, CA, CNotD, CNotA, CNegD, CNegA,
                 CDp1, CAp1, CDm1, CAm1, CDpA, CDmA, CAmD, CDandA, CDorA};
    sweep_exp = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0011, 16'h0003, 16'hFFEE,
                  16'hFFFC, 16'hFFEF, 16'hFFFD, 16'h0012, 16'h0004, 16'h0010,
                  16'h0002, 16'h0014, 16'h000E, 16'hFFF2, 16'h0001, 16'h0013};

    // Reset state
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst.pc", dut.cpu_inst.pc_q, 15'd0);
    check("rst.a", dut.cpu_inst.a_q, 16'd0);
    check("rst.d", dut.cpu_inst.d_q, 16'd0);

    // Store: @5; D=A; @100; M=D
    prog = {ainst(5), cinst(1'b0, CA, DD, 3'b0), ainst(100), cinst(1'b0, CD, DM, 3'b0)};
    load_and_start();
    run("store", 3);
    check("store.we", dut.we, 1'b1);
    check("store.addr", dut.ram_address, 15'h0064);
    check("store.outm", dut.cpu_out_m, 16'h0005);
    run("store", 2);
    check("store.ram", dut.ram[100], 16'h0005);

    // Add: @2; D=A; @3; D=D+A; @0; M=D
    prog = {ainst(2), cinst(1'b0, CA, DD, 3'b0), ainst(3), cinst(1'b0, CDpA, DD, 3'b0),
            ainst(0), cinst(1'b0, CD, DM, 3'b0)};
    load_and_start();
    run("add", 7);
    check("add.ram", dut.ram[0], 16'h0005);

    // Jumps: unconditional, JGT falls through on negative D, JLT taken
    prog = {};
    repeat (14) prog.push_back(16'h0000);
    prog[0]  = ainst(10);
    prog[1]  = cinst(1'b0, CZero, DNone, 3'b111);
    prog[10] = cinst(1'b0, CNeg1, DD, 3'b000);
    prog[11] = ainst(20);
    prog[12] = cinst(1'b0, CD, DNone, 3'b001);
    prog[13] = cinst(1'b0, CD, DNone, 3'b100);
    load_and_start();
    run("jmp", 2);
    check("jmp.pc10", dut.cpu_inst.pc_q, 15'd10);
    run("jmp", 3);
    check("jgt.fall", dut.cpu_inst.pc_q, 15'd13);
    run("jmp", 1);
    check("jlt.take", dut.cpu_inst.pc_q, 15'd20);

    // Read-modify-write: RAM[7]=0x00FF then @7; AM=M+1
    prog = {ainst(255), cinst(1'b0, CA, DD, 3'b0), ainst(7), cinst(1'b0, CD, DM, 3'b0),
            ainst(7), cinst(1'b1, CAp1, DAM, 3'b0)};
    load_and_start();
    run("rmw", 5);
    check("rmw.we", dut.we, 1'b1);
    check("rmw.addr", dut.ram_address, 15'd7);
    check("rmw.outm", dut.cpu_out_m, 16'h0100);
    run("rmw", 1);
    check("rmw.a", dut.cpu_inst.a_q, 16'h0100);
    check("rmw.ram", dut.ram[7], 16'h0100);

    // ALU sweep with D=0x0011, A=0x0003
    prog = {ainst(17), cinst(1'b0, CA, DD, 3'b0), ainst(3)};
    for (int i = 0; i < 18; i++) prog.push_back(cinst(1'b0, comp_tab[i], DM, 3'b0));
    load_and_start();
    run("sweep", 3);
    for (int i = 0; i < 18; i++) begin
      check($sformatf("sweep%0d", i), dut.cpu_out_m, sweep_exp[i]);
      cycle("sweep");
    end

    // Mid-run reset: ROM[0] is M=D+1, so we stays high in reset but RAM must not change
    prog = {cinst(1'b0, CDp1, DM, 3'b0), ainst(42), cinst(1'b0, CA, DD, 3'b0), ainst(0),
            cinst(1'b0, CD, DM, 3'b0)};
    load_and_start();
    run("mid", 5);
    #2 Reset = 1'b0;
    m_pc = '0;
    m_a  = '0;
    m_d  = '0;
    #1;
    check("mid.pc", dut.cpu_inst.pc_q, 15'd0);
    check("mid.a", dut.cpu_inst.a_q, 16'd0);
    check("mid.d", dut.cpu_inst.d_q, 16'd0);
    check("mid.we", dut.we, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    check("mid.nowr", dut.ram[0], 16'd42);
    check("mid.hold", dut.cpu_inst.pc_q, 15'd0);
    Reset = 1'b1;
    cycle("mid");
    check("mid.rerun", dut.ram[0], 16'd1);

    // Seed RAM[0..15] with random values, then random programs over that window
    prog = {};
    for (int k = 0; k < 16; k++) begin
      prog.push_back(ainst($urandom_range(0, 32767)));
      prog.push_back(cinst(1'b0, CA, DD, 3'b0));
      prog.push_back(ainst(k));
      prog.push_back(cinst(1'b0, CD, DM, 3'b0));
    end
    load_and_start();
    run("seed", 64);
    for (int p = 0; p < 4; p++) begin
      prog = {};
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          prog.push_back(ainst($urandom_range(0, 15)));
        end else begin
          prog.push_back(cinst(1'($urandom_range(0, 1)), comp_tab[$urandom_range(0, 17)],
                               3'($urandom_range(0, 3)),
                               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0));
        end
      end
      load_and_start();
      run($sformatf("rnd%0d", p), 48);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_garage.md
CPU_GARAGE -- requirements
Module: cpu_garage

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 1024, meaning instruction ROM words (16-bit).
REQ-002 SHALL have parameter RAM_DEPTH, default 1024, meaning data RAM words (16-bit).
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have no other ports; observability is through the internal nets required by REQ-006.
REQ-006 SHALL expose these internal nets under these exact hierarchical names:
- we (1): RAM write enable.
- ram_address (15): data address, equal to register A.
- cpu_out_m (16): write data.
- rom_inst.mem: unpacked array [ROM_DEPTH-1:0] of 16-bit words, forceable as a whole array.
- cpu_inst: the core instance.

Function
REQ-007 SHALL implement the Hack ISA single-cycle: one instruction per Clk, ROM fetched combinationally at PC.
REQ-008 SHALL treat instr[15]=0 as an A-instruction: A <= {0, instr[14:0]}, D unchanged, we=0, PC <= PC+1.
REQ-009 SHALL treat instr[15]=1 as a C-instruction with fields a=instr[12], zx,nx,zy,ny,f,no=instr[11:6], dA,dD,dM=instr[5:3], jlt,jeq,jgt=instr[2:0]; instr[14:13] are ignored.
REQ-010 SHALL select ALU y as RAM[A] when a=1, else A; x = D.
REQ-011 SHALL compute the ALU as follows, all 16-bit two's complement with wrap-around:
- zx zeroes x, then nx inverts x.
- zy zeroes y, then ny inverts y.
- f=1 gives x+y; f=0 gives x&y.
- no inverts the result.
REQ-012 SHALL derive zr = (out==0) and ng = out[15].
REQ-013 SHALL drive we = dM of a C-instruction, combinationally, with cpu_out_m = ALU out and ram_address = current A[14:0].
REQ-014 SHALL write RAM[ram_address mod RAM_DEPTH] at the rising edge while we=1.
REQ-015 SHALL read RAM asynchronously, with the address reduced mod RAM_DEPTH.
REQ-016 SHALL load dA into A and dD into D at the edge.
REQ-017 SHALL make the M write, A load and jump of one instruction all use the pre-edge A (e.g. AM=M+1 writes the old address).
REQ-018 SHALL take a jump when (jlt&ng)|(jeq&zr)|(jgt&~ng&~zr), loading PC <= A[14:0] (pre-edge A); otherwise PC <= PC+1.
REQ-019 SHALL wrap PC mod ROM_DEPTH on fetch; PC itself is 15 bits and wraps from 0x7FFF to 0.

Reset
REQ-020 SHALL, while Reset=0, asynchronously force PC=0, A=0 and D=0, and hold them there.
REQ-021 SHALL leave we at the value decoded from ROM[0] while in reset, but SHALL suppress RAM writes while Reset=0.
REQ-022 SHALL NOT reset or initialise RAM or ROM contents.
REQ-023 SHALL begin executing ROM[0] at the first rising edge after Reset returns to 1.

Configuration
REQ-024 SHALL, when CPU_GARAGE_ASSERT_EN is defined, compile in concurrent assertions:
- we, ram_address and cpu_out_m are never X/Z outside reset.
- PC < ROM_DEPTH, or a warning is reported.
REQ-025 SHALL, when CPU_GARAGE_ASSERT_EN is undefined, contain no assertion code and behave identically otherwise.

Structure
REQ-026 SHALL place in package cpu_garage_pkg:
- word width (16) and address width (15).
- instruction bit-field position constants.
- a packed struct typedef for the C-instruction fields.
REQ-027 SHALL split the design into three parts:
- sub-module cpu_garage_core (instance cpu_inst): PC, A, D, decode and ALU.
- ROM storage instance rom_inst.
- RAM array in the top.

Verification
REQ-028 SHALL pass a store test: program "@5; D=A; @100; M=D" gives one write cycle with ram_address=0x0064, cpu_out_m=0x0005, we=1.
REQ-029 SHALL pass an add test: program "@2; D=A; @3; D=D+A; @0; M=D" writes 0x0005 to address 0.
REQ-030 SHALL pass a jump test: after "@10; 0;JMP", PC=10 on the next cycle; "D;JGT" with D=0xFFFF falls through to PC+1, while "D;JLT" jumps.
REQ-031 SHALL pass a read-modify-write test: with RAM[7]=0x00FF, "@7; AM=M+1" writes 0x0100 to address 7, then A=0x0100.
REQ-032 SHALL pass a mid-run reset test: Reset=0 between edges gives PC=A=D=0 immediately with no RAM write; after release, ROM[0] executes again.
REQ-033 SHALL pass an ALU sweep: all 18 standard Hack comp codes with D=0x0011 and A=0x0003 match the ISA table (e.g. D-A=0x000E, !D=0xFFEE, -1=0xFFFF).
